// File: rtl/multiexp_g1_counter_pkg.sv
// ---------------------------------------------------------------------------
// multiexp_g1_counter_pkg
//
// Purpose:
//   Shared types and helpers for the multiexp G1 multi-channel counter bank.
//   - lane_op_e   : per-lane operation selected in a given cycle
//   - *_lsb()     : lane-slicing helpers that give the LSB position of lane i
//                   inside a flattened per-lane bus (step, load_value, count)
//   - width_ones(): all-ones constant for a given width
//   - width_one() : the constant 1 for a given width
//
// Ports: none (package).
// Configuration: none here. MULTIEXP_G1_COUNTER_SAT_EN is consumed by the
//   lane sub-module.
// ---------------------------------------------------------------------------
package multiexp_g1_counter_pkg;

    // Widest lane the constant helpers can describe.
    localparam int MAX_W = 64;

    // Operation a lane performs in a cycle. rst is handled separately because
    // it also clears the pulse outputs.
    typedef enum logic [1:0] {
        OP_HOLD = 2'd0,
        OP_LOAD = 2'd1,
        OP_UP   = 2'd2,
        OP_DOWN = 2'd3
    } lane_op_e;

    // LSB of lane 'lane' in a flattened bus with 'w' bits per lane.
    function automatic int lane_lsb(input int lane, input int w);
        return lane * w;
    endfunction

    // LSB of lane 'lane' inside the flattened step bus.
    function automatic int step_lsb(input int lane, input int step_w);
        return lane_lsb(lane, step_w);
    endfunction

    // LSB of lane 'lane' inside the flattened load_value bus.
    function automatic int load_lsb(input int lane, input int width);
        return lane_lsb(lane, width);
    endfunction

    // LSB of lane 'lane' inside the flattened count bus.
    function automatic int count_lsb(input int lane, input int width);
        return lane_lsb(lane, width);
    endfunction

    // All-ones value of width 'w', right-aligned in a MAX_W-bit vector.
    function automatic logic [MAX_W-1:0] width_ones(input int w);
        if (w >= MAX_W) begin
            return '1;
        end
        return (64'd1 << w) - 64'd1;
    endfunction

    // The value 1, right-aligned in a MAX_W-bit vector.
    function automatic logic [MAX_W-1:0] width_one(input int w);
        if (w <= 0) begin
            return '0;
        end
        return 64'd1;
    endfunction

endpackage

// File: rtl/multiexp_g1_counter_lane.sv
// ---------------------------------------------------------------------------
// multiexp_g1_counter_lane
//
// Purpose:
//   One lane of the multiexp G1 counter bank. It holds the registered count
//   and the status flags that are updated in the same cycle as the count.
//   Priority: rst > load > (incr XOR decr) > hold. If incr and decr are both
//   set, or if step is zero, the lane holds.
//
// Configuration:
//   MULTIEXP_G1_COUNTER_SAT_EN defined   -> saturating arithmetic
//   MULTIEXP_G1_COUNTER_SAT_EN undefined -> wrapping arithmetic (default)
//
// Ports:
//   clk         in   clock
//   rst         in   synchronous, active-high reset
//   clken       in   clock enable. When low, count and flags hold and the
//                    pulse outputs are cleared.
//   load        in   load strobe
//   incr        in   increment request
//   decr        in   decrement request
//   step        in   [C_STEP_W-1:0] step magnitude
//   load_value  in   [C_WIDTH-1:0]  load data
//   count       out  [C_WIDTH-1:0]  registered count
//   is_zero     out  registered, count == 0
//   is_max      out  registered, count == all-ones
//   zero_event  out  one-cycle pulse, count became 0 from non-zero
//   ovf         out  one-cycle pulse, a step crossed the 0 or MAX boundary
// ---------------------------------------------------------------------------
module multiexp_g1_counter_lane
    import multiexp_g1_counter_pkg::*;
#(
    parameter int                 C_WIDTH  = 16,
    parameter int                 C_STEP_W = 4,
    parameter logic [C_WIDTH-1:0] C_INIT   = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clken,
    input  logic                load,
    input  logic                incr,
    input  logic                decr,
    input  logic [C_STEP_W-1:0] step,
    input  logic [C_WIDTH-1:0]  load_value,
    output logic [C_WIDTH-1:0]  count,
    output logic                is_zero,
    output logic                is_max,
    output logic                zero_event,
    output logic                ovf
);

    // The helpers return MAX_W-bit constants, so C_WIDTH must not exceed MAX_W.
    localparam logic [MAX_W-1:0]   ONES_WIDE = width_ones(C_WIDTH);
    localparam logic [C_WIDTH-1:0] MAX_VAL   = ONES_WIDE[C_WIDTH-1:0];

    lane_op_e           op;
    logic [C_WIDTH:0]   step_ext;
    logic [C_WIDTH:0]   sum;
    logic [C_WIDTH:0]   diff;
    logic               step_zero;
    logic [C_WIDTH-1:0] next_count;
    logic               next_ovf;

    // Choose this cycle's operation. When incr and decr are both set, they
    // cancel and the lane holds.
    always_comb begin
        op = OP_HOLD;
        if (load) begin
            op = OP_LOAD;
        end else if (incr && !decr) begin
            op = OP_UP;
        end else if (decr && !incr) begin
            op = OP_DOWN;
        end
    end

    // Compute at one extra bit. The top bit of sum is the carry out, and the
    // top bit of diff is the borrow.
    always_comb begin
        step_ext  = {{(C_WIDTH + 1 - C_STEP_W){1'b0}}, step};
        sum       = {1'b0, count} + step_ext;
        diff      = {1'b0, count} - step_ext;
        step_zero = (step == '0);
    end

    // Compute the next count and the overflow flag. On overflow, the wrap
    // build keeps the low C_WIDTH bits and the saturate build clamps to the
    // boundary that was crossed.
    always_comb begin
        next_count = count;
        next_ovf   = 1'b0;
        case (op)
            OP_LOAD: begin
                next_count = load_value;
            end
            OP_UP: begin
                if (!step_zero) begin
                    next_count = sum[C_WIDTH-1:0];
                    if (sum[C_WIDTH]) begin
                        next_ovf = 1'b1;
`ifdef MULTIEXP_G1_COUNTER_SAT_EN
                        next_count = MAX_VAL;
`else
                        next_count = sum[C_WIDTH-1:0];
`endif
                    end
                end
            end
            OP_DOWN: begin
                if (!step_zero) begin
                    next_count = diff[C_WIDTH-1:0];
                    if (diff[C_WIDTH]) begin
                        next_ovf = 1'b1;
`ifdef MULTIEXP_G1_COUNTER_SAT_EN
                        next_count = '0;
`else
                        next_count = diff[C_WIDTH-1:0];
`endif
                    end
                end
            end
            default: begin
                next_count = count;
            end
        endcase
    end

    // Update the count and all flags together. The flags are derived from
    // next_count, so they always match the count they are registered with.
    // Pulses are cleared in any cycle where the lane is frozen.
    always_ff @(posedge clk) begin
        if (rst) begin
            count      <= C_INIT;
            is_zero    <= (C_INIT == '0);
            is_max     <= (C_INIT == MAX_VAL);
            zero_event <= 1'b0;
            ovf        <= 1'b0;
        end else if (clken) begin
            count      <= next_count;
            is_zero    <= (next_count == '0);
            is_max     <= (next_count == MAX_VAL);
            zero_event <= (next_count == '0) && (count != '0);
            ovf        <= next_ovf;
        end else begin
            zero_event <= 1'b0;
            ovf        <= 1'b0;
        end
    end

endmodule

// File: rtl/multiexp_g1_multi_counter.sv
// ---------------------------------------------------------------------------
// multiexp_g1_multi_counter
//
// Purpose:
//   Bank of C_CHANNELS independent up/down counters for the multiexp G1
//   kernel control path. Each lane has its own step and its own
//   load/incr/decr strobes. Strobes on different lanes are all honoured in
//   the same cycle.
//
// Configuration:
//   MULTIEXP_G1_COUNTER_SAT_EN defined   -> lanes saturate at 0 / all-ones
//   MULTIEXP_G1_COUNTER_SAT_EN undefined -> lanes wrap modulo 2^C_WIDTH
//
// Ports:
//   clk         in   clock
//   rst         in   synchronous, active-high reset
//   clken       in   global clock enable. When low, all state is frozen.
//   load        in   [C_CHANNELS-1:0] per-lane load strobe
//   incr        in   [C_CHANNELS-1:0] per-lane increment request
//   decr        in   [C_CHANNELS-1:0] per-lane decrement request
//   step        in   [C_CHANNELS*C_STEP_W-1:0] per-lane step (lane i at i*C_STEP_W)
//   load_value  in   [C_CHANNELS*C_WIDTH-1:0]  per-lane load data (lane i at i*C_WIDTH)
//   count       out  [C_CHANNELS*C_WIDTH-1:0]  registered per-lane count
//   is_zero     out  [C_CHANNELS-1:0] registered, count == 0
//   is_max      out  [C_CHANNELS-1:0] registered, count == all-ones
//   zero_event  out  [C_CHANNELS-1:0] one-cycle pulse, lane reached 0
//   ovf         out  [C_CHANNELS-1:0] one-cycle pulse, step crossed a boundary
//   any_zero    out  OR of the registered is_zero flags
// ---------------------------------------------------------------------------
module multiexp_g1_multi_counter
    import multiexp_g1_counter_pkg::*;
#(
    parameter int                 C_CHANNELS = 4,
    parameter int                 C_WIDTH    = 16,
    parameter int                 C_STEP_W   = 4,
    parameter logic [C_WIDTH-1:0] C_INIT     = '0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           clken,
    input  logic [C_CHANNELS-1:0]          load,
    input  logic [C_CHANNELS-1:0]          incr,
    input  logic [C_CHANNELS-1:0]          decr,
    input  logic [C_CHANNELS*C_STEP_W-1:0] step,
    input  logic [C_CHANNELS*C_WIDTH-1:0]  load_value,
    output logic [C_CHANNELS*C_WIDTH-1:0]  count,
    output logic [C_CHANNELS-1:0]          is_zero,
    output logic [C_CHANNELS-1:0]          is_max,
    output logic [C_CHANNELS-1:0]          zero_event,
    output logic [C_CHANNELS-1:0]          ovf,
    output logic                           any_zero
);

    // Instantiate one lane per channel. Each lane takes its own slice of the
    // flattened buses.
    for (genvar g = 0; g < C_CHANNELS; g++) begin : g_lane
        multiexp_g1_counter_lane #(
            .C_WIDTH  (C_WIDTH),
            .C_STEP_W (C_STEP_W),
            .C_INIT   (C_INIT)
        ) u_lane (
            .clk        (clk),
            .rst        (rst),
            .clken      (clken),
            .load       (load[g]),
            .incr       (incr[g]),
            .decr       (decr[g]),
            .step       (step[step_lsb(g, C_STEP_W) +: C_STEP_W]),
            .load_value (load_value[load_lsb(g, C_WIDTH) +: C_WIDTH]),
            .count      (count[count_lsb(g, C_WIDTH) +: C_WIDTH]),
            .is_zero    (is_zero[g]),
            .is_max     (is_max[g]),
            .zero_event (zero_event[g]),
            .ovf        (ovf[g])
        );
    end

    // any_zero is a plain OR of flop outputs. It changes in the same cycle as
    // the per-lane is_zero flags, so it is never stale relative to them.
    assign any_zero = |is_zero;

endmodule

// File: tb/tb_multiexp_g1_multi_counter.sv
// ---------------------------------------------------------------------------
// tb_multiexp_g1_multi_counter
//
// Purpose:
//   Self-checking bench for multiexp_g1_multi_counter configured with
//   C_CHANNELS=2, C_WIDTH=4, C_STEP_W=3, C_INIT=0.
//   The bench runs a directed sequence and then randomized traffic. A
//   reference model in plain integer arithmetic predicts every output.
//   Define MULTIEXP_G1_COUNTER_SAT_EN to check the saturating build.
// ---------------------------------------------------------------------------
module tb_multiexp_g1_multi_counter;

    localparam int NCH = 2;
    localparam int W   = 4;
    localparam int SW  = 3;
    localparam int MAXV = 15;
`ifdef MULTIEXP_G1_COUNTER_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             clken;
    logic [NCH-1:0]   load, incr, decr;
    logic [NCH*SW-1:0] step;
    logic [NCH*W-1:0] load_value;
    logic [NCH*W-1:0] count;
    logic [NCH-1:0]   is_zero, is_max, zero_event, ovf;
    logic             any_zero;

    int vectors   = 0;
    int miscompares = 0;

    // Reference state: per-lane count and the pulses expected after the last edge.
    int m_cnt [NCH];
    bit m_zev [NCH];
    bit m_ovf [NCH];

    multiexp_g1_multi_counter #(
        .C_CHANNELS (NCH),
        .C_WIDTH    (W),
        .C_STEP_W   (SW),
        .C_INIT     (4'd0)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .clken      (clken),
        .load       (load),
        .incr       (incr),
        .decr       (decr),
        .step       (step),
        .load_value (load_value),
        .count      (count),
        .is_zero    (is_zero),
        .is_max     (is_max),
        .zero_event (zero_event),
        .ovf        (ovf),
        .any_zero   (any_zero)
    );

    always #5 clk = ~clk;

    // Compare one observed value with the expected value and count the result.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Advance the reference model by one clock edge, using plain integer
    // arithmetic on the counter rules.
    task automatic modelStep(input bit r, input bit ce, input bit [NCH-1:0] ld,
                             input bit [NCH-1:0] inc, input bit [NCH-1:0] dec,
                             input int st [NCH], input int lv [NCH]);
        for (int i = 0; i < NCH; i++) begin
            int old_v, nv, t;
            bit o;
            if (r) begin
                m_cnt[i] = 0; m_zev[i] = 0; m_ovf[i] = 0;
            end else if (!ce) begin
                m_zev[i] = 0; m_ovf[i] = 0;
            end else begin
                old_v = m_cnt[i]; nv = old_v; o = 0;
                if (ld[i]) begin
                    nv = lv[i];
                end else if ((inc[i] != dec[i]) && st[i] != 0) begin
                    t = inc[i] ? old_v + st[i] : old_v - st[i];
                    if (t > MAXV) begin
                        o = 1; nv = SAT ? MAXV : t - (MAXV + 1);
                    end else if (t < 0) begin
                        o = 1; nv = SAT ? 0 : t + (MAXV + 1);
                    end else begin
                        nv = t;
                    end
                end
                m_zev[i] = (nv == 0) && (old_v != 0);
                m_ovf[i] = o;
                m_cnt[i] = nv;
            end
        end
    endtask

    // Compare every DUT output with the model state.
    task automatic checkAll();
        logic [NCH-1:0] ez, em;
        bit az;
        az = 0;
        for (int i = 0; i < NCH; i++) begin
            checkOutput($sformatf("count%0d", i), 32'(count[i*W +: W]), 32'(m_cnt[i]));
            checkOutput($sformatf("zero_event%0d", i), 32'(zero_event[i]), 32'(m_zev[i]));
            checkOutput($sformatf("ovf%0d", i), 32'(ovf[i]), 32'(m_ovf[i]));
            ez[i] = (m_cnt[i] == 0);
            em[i] = (m_cnt[i] == MAXV);
            az = az | ez[i];
        end
        checkOutput("is_zero", 32'(is_zero), 32'(ez));
        checkOutput("is_max", 32'(is_max), 32'(em));
        checkOutput("any_zero", 32'(any_zero), 32'(az));
    endtask

    // Drive one cycle of stimulus, wait for the edge, then update the model
    // and check the outputs one time unit after the edge.
    task automatic applyStimulus(input bit r, input bit ce, input bit [NCH-1:0] ld,
                                 input bit [NCH-1:0] inc, input bit [NCH-1:0] dec,
                                 input int st0, input int st1, input int lv0, input int lv1);
        int st [NCH];
        int lv [NCH];
        st[0] = st0; st[1] = st1; lv[0] = lv0; lv[1] = lv1;
        rst   = r;
        clken = ce;
        load  = ld;
        incr  = inc;
        decr  = dec;
        step       = {SW'(st1), SW'(st0)};
        load_value = {W'(lv1), W'(lv0)};
        @(posedge clk);
        #1;
        modelStep(r, ce, ld, inc, dec, st, lv);
        checkAll();
    endtask

    initial begin
        $display("[TB] start, saturating build = %0d", SAT);
        for (int i = 0; i < NCH; i++) begin
            m_cnt[i] = 0; m_zev[i] = 0; m_ovf[i] = 0;
        end

        // Reset and release.
        applyStimulus(1, 1, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0);
        applyStimulus(1, 1, 2'b11, 2'b00, 2'b00, 0, 0, 9, 9);
        checkOutput("rst_is_zero", 32'(is_zero), 32'd3);
        checkOutput("rst_any_zero", 32'(any_zero), 32'd1);
        applyStimulus(0, 1, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0);

        // Lane 0: load 5, then decrement by 2 three times.
        applyStimulus(0, 1, 2'b01, 2'b00, 2'b00, 0, 0, 5, 0);
        applyStimulus(0, 1, 2'b00, 2'b00, 2'b01, 2, 0, 0, 0);
        applyStimulus(0, 1, 2'b00, 2'b00, 2'b01, 2, 0, 0, 0);
        checkOutput("dir_lane0_1", 32'(count[3:0]), 32'd1);
        applyStimulus(0, 1, 2'b00, 2'b00, 2'b01, 2, 0, 0, 0);
        checkOutput("dir_lane0_under", 32'(count[3:0]), SAT ? 32'd0 : 32'd15);
        checkOutput("dir_lane0_ovf", 32'(ovf[0]), 32'd1);
        checkOutput("dir_lane0_zev", 32'(zero_event[0]), SAT ? 32'd1 : 32'd0);

        // Lane 1: load 14, then increment by 1 twice.
        applyStimulus(0, 1, 2'b10, 2'b00, 2'b00, 0, 0, 0, 14);
        applyStimulus(0, 1, 2'b00, 2'b10, 2'b00, 0, 1, 0, 0);
        checkOutput("dir_lane1_max", 32'(is_max[1]), 32'd1);
        applyStimulus(0, 1, 2'b00, 2'b10, 2'b00, 0, 1, 0, 0);
        checkOutput("dir_lane1_over", 32'(count[7:4]), SAT ? 32'd15 : 32'd0);
        checkOutput("dir_lane1_ovf", 32'(ovf[1]), 32'd1);

        // Lane 0 at 7: incr and decr together hold; step 0 also holds.
        applyStimulus(0, 1, 2'b01, 2'b00, 2'b00, 0, 0, 7, 0);
        applyStimulus(0, 1, 2'b00, 2'b01, 2'b01, 3, 0, 0, 0);
        applyStimulus(0, 1, 2'b00, 2'b01, 2'b00, 0, 0, 0, 0);
        checkOutput("dir_hold7", 32'(count[3:0]), 32'd7);

        // clken low freezes the lane; clken high resumes counting.
        for (int k = 0; k < 4; k++)
            applyStimulus(0, 0, 2'b00, 2'b01, 2'b00, 1, 0, 0, 0);
        checkOutput("dir_frozen", 32'(count[3:0]), 32'd7);
        applyStimulus(0, 1, 2'b00, 2'b01, 2'b00, 1, 0, 0, 0);
        applyStimulus(0, 1, 2'b00, 2'b01, 2'b00, 1, 0, 0, 0);
        checkOutput("dir_resume", 32'(count[3:0]), 32'd9);

        // rst overrides a simultaneous load.
        applyStimulus(1, 1, 2'b11, 2'b00, 2'b00, 0, 0, 9, 9);
        checkOutput("dir_rst_load", 32'(count), 32'd0);

        // Lane 0 decrements 1->0 while lane 1 increments 0->1 in the same cycle.
        applyStimulus(0, 1, 2'b01, 2'b00, 2'b00, 0, 0, 1, 0);
        applyStimulus(0, 1, 2'b00, 2'b10, 2'b01, 1, 1, 0, 0);
        checkOutput("dir_sim_zev", 32'(zero_event), 32'd1);
        checkOutput("dir_sim_is_zero", 32'(is_zero), 32'd1);

        // Randomized traffic. Load values are biased toward the boundaries.
        for (int n = 0; n < 400; n++) begin
            bit r, ce;
            bit [NCH-1:0] ld, inc, dec;
            int lv0, lv1;
            r   = ($urandom_range(31) == 0);
            ce  = ($urandom_range(3) != 0);
            ld  = NCH'($urandom_range(7) == 0) | (NCH'($urandom_range(7) == 0) << 1);
            inc = NCH'($urandom_range(3));
            dec = NCH'($urandom_range(3));
            lv0 = ($urandom_range(3) == 0) ? 0 : (($urandom_range(3) == 0) ? MAXV : int'($urandom_range(MAXV)));
            lv1 = ($urandom_range(3) == 0) ? 0 : (($urandom_range(3) == 0) ? MAXV : int'($urandom_range(MAXV)));
            applyStimulus(r, ce, ld, inc, dec, int'($urandom_range(7)), int'($urandom_range(7)), lv0, lv1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/multiexp_g1_multi_counter.md
# multiexp_g1_multi_counter

Multi-channel, parametrised up/down counter bank for the multiexp G1 kernel control path. It replaces single-lane counters wherever the kernel tracks several independent quantities, such as per-window bucket indices, outstanding AXI beats or per-lane work remaining. Each channel supports a programmable step, wrap or saturate arithmetic, and registered zero/max/overflow status that stays coherent with the count.

## Interface
- C_CHANNELS, 4, number of independent counter lanes (≥1)
- C_WIDTH, 16, counter width per lane (≥2)
- C_STEP_W, 4, width of per-lane step value (1..C_WIDTH)
- C_INIT, 0, reset value of every lane (C_WIDTH bits)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- clken  in  1  global clock enable; low freezes all state
- load  in  C_CHANNELS  per-lane load strobe
- incr  in  C_CHANNELS  per-lane increment request
- decr  in  C_CHANNELS  per-lane decrement request
- step  in  C_CHANNELS*C_STEP_W  per-lane step magnitude; lane i at [i*C_STEP_W +: C_STEP_W]
- load_value  in  C_CHANNELS*C_WIDTH  per-lane load data; lane i at [i*C_WIDTH +: C_WIDTH]
- count  out  C_CHANNELS*C_WIDTH  registered count per lane
- is_zero  out  C_CHANNELS  registered, count==0
- is_max  out  C_CHANNELS  registered, count==all-ones
- zero_event  out  C_CHANNELS  one-cycle pulse, lane reached 0 from non-zero
- ovf  out  C_CHANNELS  one-cycle pulse, step crossed 0 or MAX boundary
- any_zero  out  1  registered OR of is_zero

## Operation
- Per-lane priority: rst > load > (incr XOR decr) > hold. incr&decr or neither = hold.
- Load: count <= load_value; ovf=0; zero_event=1 iff load_value==0 and old count!=0.
- Up: next = count + step (zero-extended, computed at C_WIDTH+1 bits); ovf=1 if carry out.
- Down: next = count - step; ovf=1 if borrow.
- step==0 with incr/decr: hold; ovf=0, zero_event=0.
- Overflow result: modulo 2^C_WIDTH (wrap) or clamped; see Configuration.
- is_zero, is_max, any_zero are computed from the next value and registered with count. They are never stale relative to count.
- zero_event = (next==0) && (count!=0), registered. Holding at 0 does not pulse.
- Lanes are fully independent. Simultaneous strobes on different lanes are all honoured in the same cycle.

## Timing
- Reset values: count=C_INIT, is_zero=(C_INIT==0), is_max=(C_INIT==all-ones), any_zero=OR of is_zero, zero_event=0, ovf=0.
- Latency: one cycle from strobe to updated count and flags.
- clken low: count, is_zero, is_max and any_zero hold. zero_event and ovf are forced to 0 that cycle.
- rst asserted mid-operation: overrides all strobes in that cycle, including load.
- No handshake. Strobes are sampled every clken cycle; a level-held incr counts every cycle.

## Configuration
- MULTIEXP_G1_COUNTER_SAT_EN defined: saturating arithmetic. Up overflow clamps to all-ones, down underflow clamps to 0. ovf still pulses. zero_event fires when clamping to 0 from non-zero.
- Undefined (default): wrapping arithmetic modulo 2^C_WIDTH. ovf pulses on wrap.

## Structure
- Package multiexp_g1_counter_pkg:
  - lane-slicing helper functions (step, load_value, count field extraction)
  - a localparam-style function computing all-ones / one for a given width
- Sub-module multiexp_g1_counter_lane: one lane's count/flags/pulses. The top generates C_CHANNELS instances and ORs is_zero into any_zero.

## Test plan
All scenarios use C_CHANNELS=2, C_WIDTH=4, C_STEP_W=3, C_INIT=0.
- Reset release -> count=0,0; is_zero=2'b11; is_max=0; any_zero=1; pulses 0.
- Lane0 load 5, then decr step=2 three times -> counts 5,3,1. Then wrap build: 15, ovf=1, zero_event=0. SAT_EN build: 0, ovf=1, zero_event=1.
- Lane1 load 14, incr step=1 -> 15 with is_max=1. Next incr: wrap build gives 0, ovf=1, zero_event=1. SAT_EN build gives 15, ovf=1, is_max stays 1.
- Lane0 incr=decr=1 with step=3 at count 7 -> holds 7, no pulses. incr with step=0 -> holds 7.
- clken=0 while lane0 incr held for 4 cycles -> count frozen, pulses 0. clken=1 -> +1 per cycle.
- rst and load (value 9) in the same cycle on both lanes -> both lanes 0. Simultaneous lane0 decr 1→0 and lane1 incr 0→1 -> zero_event=2'b01, any_zero=1, then is_zero=2'b01.
